// File: rtl/mips_pkg.sv
// Shared constants and state encoding for the fetch stage.
package mips_pkg;

    localparam logic [31:0] DEF_RESET_PC       = 32'h0000_0000;
    localparam logic [31:0] DEF_HALT_INSTR     = 32'hFFFF_FFFF;
    localparam logic [31:0] DEF_NOP_INSTR      = 32'h0000_0000;
    localparam int unsigned DEF_DRAIN_CYCLES   = 4;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_DRAIN   = 2'd1,
        ST_HALTED  = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: reset and squash load a NOP, hold freezes contents.
module if_id_reg
    import mips_pkg::*;
#(
    parameter logic [31:0] NOP_INSTR = DEF_NOP_INSTR
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        hold,
    input  logic        squash,
    input  logic [31:0] fetch_instr,
    input  logic [31:0] fetch_pc4,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc4
);

    always_ff @(posedge clk) begin
        if (reset) begin
            if_id_instr <= NOP_INSTR;
            if_id_pc4   <= '0;
        end else if (hold) begin
            if_id_instr <= if_id_instr;
            if_id_pc4   <= if_id_pc4;
        end else if (squash) begin
            if_id_instr <= NOP_INSTR;
            if_id_pc4   <= '0;
        end else begin
            if_id_instr <= fetch_instr;
            if_id_pc4   <= fetch_pc4;
        end
    end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: PC, next-PC selection, IF/ID register and the
// HALT drain state machine.
module if_fetch_stage
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC     = DEF_RESET_PC,
    parameter logic [31:0] HALT_INSTR   = DEF_HALT_INSTR,
    parameter logic [31:0] NOP_INSTR    = DEF_NOP_INSTR,
    parameter int unsigned DRAIN_CYCLES = DEF_DRAIN_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        stall,
    input  logic        pc_src,
    input  logic [31:0] branch_target,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    output logic [31:0] pc,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc4,
    output logic        halted
);

    localparam logic [3:0] DRAIN_LAST = 4'(DRAIN_CYCLES - 1);

    fetch_state_e state;
    logic [3:0]   drain_cnt;
    logic [31:0]  pc_plus4;
    logic         advance;
    logic         is_halt;
    logic         squash;

    assign imem_addr = pc;
    assign pc_plus4  = pc + 32'd4;
    assign is_halt   = (imem_data == HALT_INSTR);
    // An advancing edge: enabled, unstalled and not parked in HALTED.
    assign advance   = enable && !stall && (state != ST_HALTED);
    assign squash    = pc_src || (state == ST_DRAIN);

    always_ff @(posedge clk) begin
        if (reset) begin
            pc <= RESET_PC;
        end else if (advance) begin
            if (pc_src)
                pc <= branch_target;
            else if (state == ST_RUN && !is_halt)
                pc <= pc_plus4;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_RUN;
            drain_cnt <= '0;
            halted    <= 1'b0;
        end else if (advance) begin
            case (state)
                ST_RUN: begin
                    if (!pc_src && is_halt) begin
                        state     <= ST_DRAIN;
                        drain_cnt <= '0;
                    end
                end
                ST_DRAIN: begin
                    // A redirect means the HALT was fetched down the wrong path.
                    if (pc_src) begin
                        state     <= ST_RUN;
                        drain_cnt <= '0;
                    end else begin
                        drain_cnt <= drain_cnt + 4'd1;
                        if (drain_cnt == DRAIN_LAST) begin
                            state  <= ST_HALTED;
                            halted <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= state;
                end
            endcase
        end
    end

    if_id_reg #(
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id_reg (
        .clk         (clk),
        .reset       (reset),
        .hold        (!advance),
        .squash      (squash),
        .fetch_instr (imem_data),
        .fetch_pc4   (pc_plus4),
        .if_id_instr (if_id_instr),
        .if_id_pc4   (if_id_pc4)
    );

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage with a cycle-level reference model and
// hand-computed checkpoints.
module tb_if_fetch_stage;

    localparam logic [31:0] HALT = 32'hFFFF_FFFF;
    localparam logic [31:0] NOP  = 32'h0000_0000;
    localparam int          DRAIN = 4;

    logic        clk;
    logic        reset;
    logic        enable;
    logic        stall;
    logic        pc_src;
    logic [31:0] branch_target;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic [31:0] pc;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc4;
    logic        halted;

    int errors = 0;
    int checks = 0;

    logic [31:0] mem [0:63];

    if_fetch_stage #(
        .RESET_PC     (32'h0000_0000),
        .HALT_INSTR   (HALT),
        .NOP_INSTR    (NOP),
        .DRAIN_CYCLES (DRAIN)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .enable        (enable),
        .stall         (stall),
        .pc_src        (pc_src),
        .branch_target (branch_target),
        .imem_addr     (imem_addr),
        .imem_data     (imem_data),
        .pc            (pc),
        .if_id_instr   (if_id_instr),
        .if_id_pc4     (if_id_pc4),
        .halted        (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] fetch(input logic [31:0] addr);
        return mem[addr[7:2]];
    endfunction

    always_comb imem_data = fetch(imem_addr);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: drain is a countdown of remaining advancing edges.
    logic [31:0] m_pc, m_instr, m_pc4, f;
    logic        m_halted, m_draining, m_valid;
    int          m_left;

    initial m_valid = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            m_pc = 32'h0; m_instr = NOP; m_pc4 = 32'h0;
            m_halted = 1'b0; m_draining = 1'b0; m_left = 0; m_valid = 1'b1;
        end else if (!enable || m_halted || stall) begin
            // frozen
        end else if (pc_src) begin
            m_pc = branch_target; m_instr = NOP; m_pc4 = 32'h0; m_draining = 1'b0;
        end else if (m_draining) begin
            m_instr = NOP; m_pc4 = 32'h0;
            m_left = m_left - 1;
            if (m_left == 0) m_halted = 1'b1;
        end else begin
            f = fetch(m_pc);
            m_instr = f;
            m_pc4 = m_pc + 32'd4;
            if (f == HALT) begin
                m_draining = 1'b1;
                m_left = DRAIN;
            end else begin
                m_pc = m_pc + 32'd4;
            end
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check("model pc", pc, m_pc);
            check("model imem_addr", imem_addr, m_pc);
            check("model if_id_instr", if_id_instr, m_instr);
            check("model if_id_pc4", if_id_pc4, m_pc4);
            check("model halted", {31'b0, halted}, {31'b0, m_halted});
        end
    end

    task automatic tick(input logic st, input logic ps, input logic [31:0] tgt);
        stall = st;
        pc_src = ps;
        branch_target = tgt;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'h2400_0000 + 32'(i);
        mem[0]  = 32'h2001_0005;
        mem[1]  = 32'h2002_0006;
        mem[2]  = 32'h2003_0007;
        mem[8]  = HALT;
        mem[24] = HALT;

        reset = 1'b1; enable = 1'b1; stall = 1'b0; pc_src = 1'b0; branch_target = '0;
        tick(0, 0, 0);
        tick(0, 0, 0);
        check("reset pc", pc, 32'h0);
        check("reset instr", if_id_instr, NOP);
        check("reset pc4", if_id_pc4, 32'h0);
        check("reset halted", {31'b0, halted}, 32'h0);
        reset = 1'b0;

        tick(0, 0, 0);
        tick(0, 0, 0);
        check("run pc", pc, 32'h8);
        check("run instr", if_id_instr, 32'h2002_0006);
        check("run pc4", if_id_pc4, 32'h8);

        tick(1, 0, 0);
        tick(1, 0, 0);
        check("stall pc", pc, 32'h8);
        check("stall instr", if_id_instr, 32'h2002_0006);
        tick(0, 0, 0);
        check("unstall pc", pc, 32'hC);
        check("unstall instr", if_id_instr, 32'h2003_0007);
        check("unstall pc4", if_id_pc4, 32'hC);

        tick(0, 1, 32'h40);
        check("redirect pc", pc, 32'h40);
        check("redirect bubble", if_id_instr, NOP);
        tick(0, 0, 0);
        check("target instr", if_id_instr, 32'h2400_0010);
        check("target pc", pc, 32'h44);
        tick(1, 1, 32'h100);
        check("stall+pc_src pc", pc, 32'h44);
        check("stall+pc_src instr", if_id_instr, 32'h2400_0010);

        tick(0, 1, 32'h14);
        tick(0, 0, 0);
        tick(0, 0, 0);
        tick(0, 0, 0);
        tick(0, 0, 0);
        check("halt pc", pc, 32'h20);
        check("halt instr", if_id_instr, HALT);
        check("halt pc4", if_id_pc4, 32'h24);
        tick(0, 0, 0);
        tick(0, 0, 0);
        tick(1, 0, 0);
        tick(1, 0, 0);
        tick(0, 0, 0);
        check("drain not yet halted", {31'b0, halted}, 32'h0);
        check("drain instr", if_id_instr, NOP);
        tick(0, 0, 0);
        check("halted", {31'b0, halted}, 32'h1);
        check("halted pc", pc, 32'h20);

        enable = 1'b0;
        for (int i = 0; i < 5; i++) tick(0, 1, 32'h80);
        enable = 1'b1;
        tick(0, 1, 32'h80);
        check("halted ignores pc_src", pc, 32'h20);
        check("halted held", {31'b0, halted}, 32'h1);

        reset = 1'b1;
        tick(0, 0, 0);
        reset = 1'b0;
        check("reset from halted pc", pc, 32'h0);
        check("reset from halted", {31'b0, halted}, 32'h0);

        tick(0, 0, 0);
        enable = 1'b0;
        for (int i = 0; i < 5; i++) tick(i[0], ~i[0], 32'hC0);
        enable = 1'b1;
        check("disabled pc", pc, 32'h4);
        check("disabled instr", if_id_instr, 32'h2001_0005);
        check("disabled pc4", if_id_pc4, 32'h4);

        tick(0, 1, 32'h20);
        tick(0, 1, 32'h0);
        check("halt discarded pc", pc, 32'h0);
        check("halt discarded instr", if_id_instr, NOP);
        tick(0, 0, 0);
        check("after discard pc", pc, 32'h4);

        tick(0, 1, 32'h60);
        tick(0, 0, 0);
        check("halt2 instr", if_id_instr, HALT);
        tick(0, 0, 0);
        tick(0, 1, 32'h80);
        check("drain redirect pc", pc, 32'h80);
        for (int i = 0; i < 6; i++) tick(0, 0, 0);
        check("resumed pc", pc, 32'h98);
        check("never halted", {31'b0, halted}, 32'h0);

        tick(0, 1, 32'hFFFF_FFFC);
        tick(0, 0, 0);
        check("wrap pc", pc, 32'h0);
        check("wrap pc4", if_id_pc4, 32'h0);
        check("wrap instr", if_id_instr, 32'h2400_003F);

        tick(0, 1, 32'h51);
        tick(0, 0, 0);
        check("unaligned pc", pc, 32'h55);
        check("unaligned pc4", if_id_pc4, 32'h55);
        check("unaligned instr", if_id_instr, 32'h2400_0014);

        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
